// File: rtl/flash_rx_deserializer.sv
// flash_rx_deserializer: packs the qualified serial read-data stream of the SPI
// flash read engine into bytes, queues them in a small first-word-fall-through
// FIFO and presents them to the consumer over a valid/ready handshake.
module flash_rx_deserializer #(
   parameter int DEPTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     frame_start,
   input  logic                     frame_end,
   input  logic                     bit_in,
   input  logic                     bit_valid,
   output logic [7:0]               out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     almost_full,
   output logic                     overflow,
   output logic                     partial,
   input  logic                     clear_flags,
   output logic                     busy
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
   localparam logic [AW:0] AF_LVL   = (AW+1)'(DEPTH - 2);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [7:0]  sh_q, sh_d;
   logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic        ovf_q, ovf_d, part_q, part_d;
   logic [7:0]  mem_q [DEPTH];

   logic        push;
   logic [7:0]  push_byte;
   logic        part_set;
   logic        pop, full, wr_en, ovf_set;

   // Shift one serial bit into the assembly register in the configured bit order.
   function automatic logic [7:0] shift_in(input logic [7:0] sh, input logic b);
      if (MSB_FIRST) return {sh[6:0], b};
      else           return {b, sh[7:1]};
   endfunction

   // Frame FSM and bit assembly: frame_start always restarts (and beats frame_end),
   // a bit arriving with frame_end is absorbed before the frame closes.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sh_d      = sh_q;
      push      = 1'b0;
      push_byte = shift_in(sh_q, bit_in);
      part_set  = 1'b0;
      if (frame_start) begin
         state_d  = ACTIVE;
         part_set = (state_q == ACTIVE) && (cnt_q != 3'd0);
         if (bit_valid) begin
            sh_d  = shift_in(8'h00, bit_in);
            cnt_d = 3'd1;
         end else begin
            sh_d  = 8'h00;
            cnt_d = 3'd0;
         end
      end else if (state_q == ACTIVE) begin
         if (bit_valid) begin
            if (cnt_q == 3'd7) begin
               push  = 1'b1;
               cnt_d = 3'd0;
               sh_d  = 8'h00;
            end else begin
               cnt_d = cnt_q + 3'd1;
               sh_d  = push_byte;
            end
         end
         if (frame_end) begin
            state_d  = IDLE;
            part_set = (cnt_d != 3'd0);
            cnt_d    = 3'd0;
            sh_d     = 8'h00;
         end
      end
   end

   // FIFO control: a push into a full FIFO survives only if the head leaves in the same cycle.
   always_comb begin
      level       = wptr_q - rptr_q;
      out_valid   = (level != '0);
      full        = (level == FULL_LVL);
      almost_full = (level >= AF_LVL);
      out_data    = mem_q[rptr_q[AW-1:0]];
      pop         = out_valid & out_ready;
      wr_en       = push & (~full | pop);
      ovf_set     = push & full & ~pop;
      wptr_d      = wptr_q + {{AW{1'b0}}, wr_en};
      rptr_d      = rptr_q + {{AW{1'b0}}, pop};
      ovf_d       = ovf_set  | (ovf_q  & ~clear_flags);
      part_d      = part_set | (part_q & ~clear_flags);
      busy        = (state_q == ACTIVE);
      overflow    = ovf_q;
      partial     = part_q;
   end

   // Control and assembly state with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 3'd0;
         sh_q    <= 8'h00;
         wptr_q  <= '0;
         rptr_q  <= '0;
         ovf_q   <= 1'b0;
         part_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         ovf_q   <= ovf_d;
         part_q  <= part_d;
      end
   end

   // FIFO storage; contents are meaningless outside the pointer window so no reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wptr_q[AW-1:0]] <= push_byte;
   end

endmodule

// File: tb/tb_flash_rx_deserializer.sv
// Testbench for flash_rx_deserializer: one MSB-first and one LSB-first instance
// share the stimulus; a queue-based reference model tracks both.
module tb_flash_rx_deserializer;

   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic fs = 0, fe = 0, bv = 0, bi = 0, rdy = 0, clr = 0;

   logic [7:0] od_m, od_l;
   logic       ov_m, ov_l, af_m, af_l, ovf_m, ovf_l, pt_m, pt_l, bz_m, bz_l;
   logic [3:0] lvl_m, lvl_l;

   always #5 clk = ~clk;

   flash_rx_deserializer #(.DEPTH(DEPTH), .MSB_FIRST(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .frame_start(fs), .frame_end(fe),
      .bit_in(bi), .bit_valid(bv), .out_data(od_m), .out_valid(ov_m),
      .out_ready(rdy), .level(lvl_m), .almost_full(af_m), .overflow(ovf_m),
      .partial(pt_m), .clear_flags(clr), .busy(bz_m));

   flash_rx_deserializer #(.DEPTH(DEPTH), .MSB_FIRST(1'b0)) dut_l (
      .clk(clk), .rst_n(rst_n), .frame_start(fs), .frame_end(fe),
      .bit_in(bi), .bit_valid(bv), .out_data(od_l), .out_valid(ov_l),
      .out_ready(rdy), .level(lvl_l), .almost_full(af_l), .overflow(ovf_l),
      .partial(pt_l), .clear_flags(clr), .busy(bz_l));

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit         m_active;
   bit         m_bits[$];
   logic [7:0] qm[$];
   logic [7:0] ql[$];
   bit         m_ovf, m_part;

   task automatic model_reset();
      m_active = 0; m_bits.delete(); qm.delete(); ql.delete();
      m_ovf = 0; m_part = 0;
   endtask

   task automatic model_edge();
      bit do_pop, have, pset, oset;
      logic [7:0] bm, bl;
      int sz;
      do_pop = (qm.size() > 0) && rdy;
      have = 0; pset = 0; oset = 0; bm = 0; bl = 0;
      if (fs) begin
         pset = m_active && (m_bits.size() != 0);
         m_bits.delete();
         m_active = 1;
         if (bv) m_bits.push_back(bi);
      end else if (m_active) begin
         if (bv) m_bits.push_back(bi);
         if (m_bits.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
               bm[7-i] = m_bits[i];
               bl[i]   = m_bits[i];
            end
            have = 1;
            m_bits.delete();
         end
         if (fe) begin
            if (m_bits.size() != 0) pset = 1;
            m_bits.delete();
            m_active = 0;
         end
      end
      sz = qm.size();
      if (do_pop) begin
         void'(qm.pop_front());
         void'(ql.pop_front());
      end
      if (have) begin
         if (sz < DEPTH || do_pop) begin
            qm.push_back(bm);
            ql.push_back(bl);
         end else oset = 1;
      end
      m_ovf  = oset | (m_ovf  & !clr);
      m_part = pset | (m_part & !clr);
   endtask

   task automatic model_check();
      chk("m_valid", ov_m, qm.size() != 0);
      chk("m_level", lvl_m, qm.size());
      chk("m_afull", af_m, qm.size() >= DEPTH - 2);
      chk("m_ovf", ovf_m, m_ovf);
      chk("m_partial", pt_m, m_part);
      chk("m_busy", bz_m, m_active);
      if (qm.size() != 0) chk("m_data", od_m, qm[0]);
      chk("l_valid", ov_l, ql.size() != 0);
      chk("l_level", lvl_l, ql.size());
      chk("l_afull", af_l, ql.size() >= DEPTH - 2);
      chk("l_ovf", ovf_l, m_ovf);
      chk("l_partial", pt_l, m_part);
      chk("l_busy", bz_l, m_active);
      if (ql.size() != 0) chk("l_data", od_l, ql[0]);
   endtask

   // One clock cycle: drive, check at negedge against model, advance model at posedge.
   task automatic step(input bit fs_i, input bit fe_i, input bit bv_i, input bit bi_i,
                       input bit rdy_i, input bit clr_i);
      fs = fs_i; fe = fe_i; bv = bv_i; bi = bi_i; rdy = rdy_i; clr = clr_i;
      @(negedge clk);
      model_check();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit rdy_i);
      for (int i = 0; i < 8; i++) step(0, 0, 1, b[7-i], rdy_i, 0);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit fs, fe, bv, bi, rdy, clr;
      bit ov; logic [7:0] od; int lvl; bit part;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input bit fs_i, input bit fe_i, input bit bv_i, input bit bi_i,
                      input bit rdy_i, input bit clr_i, input bit ov_i,
                      input logic [7:0] od_i, input int lvl_i, input bit part_i);
      vec_t v;
      v.fs = fs_i; v.fe = fe_i; v.bv = bv_i; v.bi = bi_i; v.rdy = rdy_i; v.clr = clr_i;
      v.ov = ov_i; v.od = od_i; v.lvl = lvl_i; v.part = part_i;
      tbl.push_back(v);
   endtask

   task automatic add_byte(input logic [7:0] b);
      for (int i = 0; i < 8; i++)
         add(0, 0, 1, b[7-i], 1, 0, (i == 7), b, (i == 7) ? 1 : 0, 0);
   endtask

   logic [7:0] byts [10];
   logic [7:0] nb, rb;

   initial begin
      // reset values while rst_n is low
      model_reset();
      #1;
      chk("rst_valid", ov_m, 0);
      chk("rst_level", lvl_m, 0);
      chk("rst_afull", af_m, 0);
      chk("rst_ovf", ovf_m, 0);
      chk("rst_partial", pt_m, 0);
      chk("rst_busy", bz_m, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // table: two MSB-first bytes, then a short frame, clear, aligned 0x81
      add(1, 0, 0, 0, 1, 0, 0, 8'h00, 0, 0);
      add_byte(8'hA5);
      add_byte(8'h3C);
      add(0, 1, 0, 0, 1, 0, 0, 8'h00, 0, 0);
      add(1, 0, 0, 0, 1, 0, 0, 8'h00, 0, 0);
      for (int i = 0; i < 5; i++) add(0, 0, 1, 1, 1, 0, 0, 8'h00, 0, 0);
      add(0, 1, 0, 0, 1, 0, 0, 8'h00, 0, 1);
      add(0, 0, 0, 0, 1, 1, 0, 8'h00, 0, 0);
      add(1, 0, 0, 0, 1, 0, 0, 8'h00, 0, 0);
      add_byte(8'h81);
      add(0, 1, 0, 0, 1, 0, 0, 8'h00, 0, 0);
      foreach (tbl[k]) begin
         step(tbl[k].fs, tbl[k].fe, tbl[k].bv, tbl[k].bi, tbl[k].rdy, tbl[k].clr);
         chk($sformatf("tbl%0d_valid", k), ov_m, tbl[k].ov);
         chk($sformatf("tbl%0d_level", k), lvl_m, tbl[k].lvl);
         chk($sformatf("tbl%0d_partial", k), pt_m, tbl[k].part);
         chk($sformatf("tbl%0d_ovf", k), ovf_m, 0);
         if (tbl[k].ov) chk($sformatf("tbl%0d_data", k), od_m, tbl[k].od);
      end

      // IDLE bits ignored; LSB-first ordering
      for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 1, 0);
      chk("idle_busy", bz_m, 0);
      chk("idle_valid", ov_m, 0);
      chk("idle_partial", pt_m, 0);
      step(1, 0, 0, 0, 0, 0);
      send_byte(8'h80, 0);
      chk("lsb_valid", ov_l, 1);
      chk("lsb_data", od_l, 8'h01);
      chk("msb_data_80", od_m, 8'h80);
      step(0, 1, 0, 0, 1, 0);
      chk("lsb_drained", ov_l, 0);

      // fill to overflow with consumer stalled
      step(1, 0, 0, 0, 0, 0);
      for (int j = 0; j < 10; j++) begin
         byts[j] = 8'($urandom_range(0, 255));
         send_byte(byts[j], 0);
         chk($sformatf("fill%0d_level", j), lvl_m, (j + 1 > 8) ? 8 : j + 1);
         chk($sformatf("fill%0d_afull", j), af_m, (j + 1) >= 6);
         chk($sformatf("fill%0d_ovf", j), ovf_m, (j + 1) > 8);
      end
      step(0, 0, 0, 0, 0, 1);
      chk("clr_ovf", ovf_m, 0);

      // full FIFO: push coincides with pop
      nb = 8'($urandom_range(0, 255));
      for (int i = 0; i < 7; i++) step(0, 0, 1, nb[7-i], 0, 0);
      chk("full_head", od_m, byts[0]);
      step(0, 0, 1, nb[0], 1, 0);
      chk("fullpop_level", lvl_m, 8);
      chk("fullpop_ovf", ovf_m, 0);
      step(0, 1, 0, 0, 0, 0);
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("drain%0d_valid", k), ov_m, 1);
         chk($sformatf("drain%0d_data", k), od_m, (k < 7) ? byts[k+1] : nb);
         step(0, 0, 0, 0, 1, 0);
      end
      chk("drain_empty", ov_m, 0);
      chk("drain_level", lvl_m, 0);

      // asynchronous reset mid-frame
      step(1, 0, 0, 0, 0, 0);
      for (int j = 0; j < 3; j++) send_byte(8'($urandom_range(0, 255)), 0);
      for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 0, 0);
      rst_n = 1'b0;
      #1;
      chk("arst_valid", ov_m, 0);
      chk("arst_level", lvl_m, 0);
      chk("arst_busy", bz_m, 0);
      chk("arst_afull", af_m, 0);
      chk("arst_partial", pt_m, 0);
      model_reset();
      #1;
      rst_n = 1'b1;
      step(1, 0, 0, 0, 1, 0);
      for (int j = 0; j < 2; j++) begin
         rb = 8'($urandom_range(0, 255));
         send_byte(rb, 1);
         chk($sformatf("post_rst%0d_valid", j), ov_m, 1);
         chk($sformatf("post_rst%0d_data", j), od_m, rb);
      end
      step(0, 1, 0, 0, 1, 0);

      // randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         int ph;
         ph = (c / 300) % 4;
         step(($urandom % 40) == 0, ($urandom % 30) == 0, ($urandom % 5) != 0,
              $urandom % 2, ($urandom % 4) < ph, ($urandom % 50) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
